// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Region decode and MMIO offsets live here so the bench and RTL agree on the map.
package dmem_pkg;

   localparam logic [3:0] MMIO_REGION = 4'hB;

   localparam logic [3:0] OFF_LED    = 4'h0;
   localparam logic [3:0] OFF_CYCLES = 4'h4;
   localparam logic [3:0] OFF_STORES = 4'h8;

   typedef enum logic {
      REG_RAM,
      REG_MMIO
   } region_e;

   function automatic region_e decode_region(input logic [3:0] top_nibble);
      return (top_nibble == MMIO_REGION) ? REG_MMIO : REG_RAM;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with per-byte write enables and a registered, write-first read port.
// Only the read register is reset; array contents survive reset.
module dmem_ram #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] idx,
   input  logic              re,
   input  logic [3:0]        we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] merged;
   logic [31:0] rdata_q;

   // New lanes where strobed, stored lanes elsewhere; feeds both the write and the read.
   always_comb begin
      merged = mem[idx];
      for (int i = 0; i < 4; i++) begin
         if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

   // rst is sampled here so a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst && (|we)) mem[idx] <= merged;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= merged;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable RAM plus MMIO LED / cycle / store counters.
// Define DMEM_ALIGN_CHK_EN to add strobe/address legality checking and the misalign output.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LED_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic             memread,
   input  logic [3:0]       memwrite,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] led
`ifdef DMEM_ALIGN_CHK_EN
   ,
   output logic             misalign
`endif
);

   region_e          region;
   region_e          sel_q;
   logic [3:0]       offset;
   logic             legal;
   logic [3:0]       wr_lanes;
   logic [3:0]       ram_we;
   logic             ram_re;
   logic [31:0]      ram_rdata;
   logic [31:0]      mmio_rdata;
   logic [31:0]      mmio_q;
   logic [31:0]      cycles_q;
   logic [31:0]      stores_q;
   logic [LED_W-1:0] led_q;
   logic [LED_W-1:0] led_d;
   logic [31:0]      led_ext;
   logic [31:0]      led_mask;
   logic [31:0]      led_new;
   logic             unused_addr;

   assign region      = decode_region(addr[31:28]);
   assign offset      = addr[3:0];
   // Upper RAM index bits alias by truncation; low bits only matter for the alignment check.
   assign unused_addr = ^{addr[27:ADDR_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
   logic wr_ok;
   logic misalign_q;

   always_comb begin
      wr_ok = 1'b0;
      case (memwrite)
         4'b0000: wr_ok = 1'b1;
         4'b0001: wr_ok = (addr[1:0] == 2'd0);
         4'b0010: wr_ok = (addr[1:0] == 2'd1);
         4'b0100: wr_ok = (addr[1:0] == 2'd2);
         4'b1000: wr_ok = (addr[1:0] == 2'd3);
         4'b0011: wr_ok = (addr[1:0] == 2'd0);
         4'b1100: wr_ok = (addr[1:0] == 2'd2);
         4'b1111: wr_ok = (addr[1:0] == 2'd0);
         default: wr_ok = 1'b0;
      endcase
   end

   assign legal    = wr_ok && !(memread && (addr[1:0] != 2'd0));
   assign misalign = misalign_q;
`else
   assign legal = 1'b1;
`endif

   assign wr_lanes = legal ? memwrite : 4'b0000;
   assign ram_we   = (region == REG_RAM) ? wr_lanes : 4'b0000;
   assign ram_re   = memread && (region == REG_RAM);

   dmem_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .idx   (addr[ADDR_W+1:2]),
      .re    (ram_re),
      .we    (ram_we),
      .wdata (writedata),
      .rdata (ram_rdata)
   );

   assign led_ext = 32'(led_q);

   always_comb begin
      mmio_rdata = '0;
      case (offset)
         OFF_LED:    mmio_rdata = led_ext;
         OFF_CYCLES: mmio_rdata = cycles_q;
         OFF_STORES: mmio_rdata = stores_q;
         default:    mmio_rdata = '0;
      endcase
   end

   // LED only takes lanes 0..1; anything above 16 bits is never written.
   assign led_mask = {16'h0000, {8{wr_lanes[1]}}, {8{wr_lanes[0]}}};
   assign led_new  = (led_ext & ~led_mask) | (writedata & led_mask);

   always_comb begin
      led_d = led_q;
      if ((region == REG_MMIO) && (offset == OFF_LED)) led_d = led_new[LED_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q    <= '0;
         cycles_q <= '0;
         stores_q <= '0;
         mmio_q   <= '0;
         sel_q    <= REG_RAM;
`ifdef DMEM_ALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         cycles_q <= cycles_q + 32'd1;
         led_q    <= led_d;
         if ((region == REG_RAM) && (|wr_lanes)) stores_q <= stores_q + 32'd1;
         if (memread) begin
            sel_q <= region;
            if (region == REG_MMIO) mmio_q <= mmio_rdata;
         end
`ifdef DMEM_ALIGN_CHK_EN
         misalign_q <= !legal;
`endif
      end
   end

   assign readdata = (sel_q == REG_MMIO) ? mmio_q : ram_rdata;
   assign led      = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM byte writes, write-first reads, MMIO map, reset.
// Follows DMEM_ALIGN_CHK_EN so the same file covers both builds.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        memread;
   logic [3:0]  memwrite;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [15:0] led;
`ifdef DMEM_ALIGN_CHK_EN
   logic        misalign;
`endif

   int vectors    = 0;
   int miscompares = 0;
   int exp_stores = 0;
   int edge_cnt   = 0;

   dmem_responder #(
      .DEPTH  (1024),
      .ADDR_W (10),
      .LED_W  (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .memread   (memread),
      .memwrite  (memwrite),
      .writedata (writedata),
      .readdata  (readdata),
      .led       (led)
`ifdef DMEM_ALIGN_CHK_EN
      ,
      .misalign  (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges seen out of reset; the CYCLES value sampled at an edge is this count before it.
   always @(posedge clk or negedge rst) begin
      if (!rst) edge_cnt <= 0;
      else      edge_cnt <= edge_cnt + 1;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memread   = 1'b0;
      memwrite  = 4'b0000;
      writedata = 32'h0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      addr = a; memwrite = s; writedata = d; memread = 1'b0;
      cycle();
      idle();
   endtask

   task automatic do_read(input logic [31:0] a);
      addr = a; memread = 1'b1; memwrite = 4'b0000;
      cycle();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      addr = 32'h0;
      #12;
      vectors++;
      if (readdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0);
      end
      vectors++;
      if (led !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_led: got %h want %h", led, 16'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_read(32'hB000_0004);
      vectors++;
      if (readdata !== 32'd3) begin
         miscompares++;
         $display("FAIL reset_cycles: got %0d want %0d", readdata, 3);
      end
   endtask

   task automatic test_word_store();
      do_write(32'h40, 4'hF, 32'h1234_5678);
      exp_stores++;
      do_read(32'h40);
      vectors++;
      if (readdata !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL word_store: got %h want %h", readdata, 32'h1234_5678);
      end
   endtask

   task automatic test_byte_store();
      do_write(32'h42, 4'b0100, 32'h00AB_0000);
      exp_stores++;
      do_read(32'h40);
      vectors++;
      if (readdata !== 32'h12AB_5678) begin
         miscompares++;
         $display("FAIL byte_store: got %h want %h", readdata, 32'h12AB_5678);
      end
   endtask

   task automatic test_same_cycle();
      addr = 32'h40; memwrite = 4'b0011; writedata = 32'h0000_BEEF; memread = 1'b1;
      cycle();
      idle();
      exp_stores++;
      vectors++;
      if (readdata !== 32'h12AB_BEEF) begin
         miscompares++;
         $display("FAIL same_cycle_merge: got %h want %h", readdata, 32'h12AB_BEEF);
      end
      // memread low: output must hold while the address wanders
      addr = 32'h0000_0200;
      cycle();
      vectors++;
      if (readdata !== 32'h12AB_BEEF) begin
         miscompares++;
         $display("FAIL read_hold: got %h want %h", readdata, 32'h12AB_BEEF);
      end
   endtask

   task automatic test_alias();
      do_read(32'h0000_1040);
      vectors++;
      if (readdata !== 32'h12AB_BEEF) begin
         miscompares++;
         $display("FAIL alias_low: got %h want %h", readdata, 32'h12AB_BEEF);
      end
      do_write(32'h0000_0FFC, 4'hF, 32'hA1B2_C3D4);
      exp_stores++;
      do_read(32'h7FFF_FFFC);
      vectors++;
      if (readdata !== 32'hA1B2_C3D4) begin
         miscompares++;
         $display("FAIL alias_top_word: got %h want %h", readdata, 32'hA1B2_C3D4);
      end
   endtask

   task automatic test_mmio();
      do_write(32'hB000_0000, 4'hF, 32'hDEAD_A5A5);
      vectors++;
      if (led !== 16'hA5A5) begin
         miscompares++;
         $display("FAIL led_write: got %h want %h", led, 16'hA5A5);
      end
      do_write(32'hB000_0000, 4'b0010, 32'h0000_3C00);
      vectors++;
      if (led !== 16'h3CA5) begin
         miscompares++;
         $display("FAIL led_lane1: got %h want %h", led, 16'h3CA5);
      end
      do_read(32'hB000_0000);
      vectors++;
      if (readdata !== 32'h0000_3CA5) begin
         miscompares++;
         $display("FAIL led_read: got %h want %h", readdata, 32'h0000_3CA5);
      end
      do_write(32'hB000_0004, 4'hF, 32'h0);
      do_read(32'hB000_0004);
      vectors++;
      if (readdata !== 32'(edge_cnt - 1)) begin
         miscompares++;
         $display("FAIL cycles_ro: got %0d want %0d", readdata, edge_cnt - 1);
      end
      do_write(32'hB000_0008, 4'hF, 32'h100);
      do_read(32'hB000_000C);
      vectors++;
      if (readdata !== 32'h0) begin
         miscompares++;
         $display("FAIL undef_offset: got %h want %h", readdata, 32'h0);
      end
      do_read(32'hB000_0008);
      vectors++;
      if (readdata !== 32'(exp_stores)) begin
         miscompares++;
         $display("FAIL stores_ro: got %0d want %0d", readdata, exp_stores);
      end
   endtask

   task automatic test_stores();
      for (int i = 0; i < 5; i++) begin
         do_write(32'h100 + 32'(4 * i), 4'hF, 32'h5000_0000 + 32'(i));
         exp_stores++;
      end
      do_read(32'hB000_0008);
      vectors++;
      if (readdata !== 32'(exp_stores)) begin
         miscompares++;
         $display("FAIL stores_count: got %0d want %0d", readdata, exp_stores);
      end
      do_read(32'h10C);
      vectors++;
      if (readdata !== 32'h5000_0003) begin
         miscompares++;
         $display("FAIL stores_data: got %h want %h", readdata, 32'h5000_0003);
      end
   endtask

`ifdef DMEM_ALIGN_CHK_EN
   task automatic test_align();
      addr = 32'h41; memwrite = 4'b0011; writedata = 32'h0000_FFFF;
      cycle();
      idle();
      vectors++;
      if (misalign !== 1'b1) begin
         miscompares++;
         $display("FAIL misalign_pulse: got %b want %b", misalign, 1'b1);
      end
      cycle();
      vectors++;
      if (misalign !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_clear: got %b want %b", misalign, 1'b0);
      end
      do_read(32'h40);
      vectors++;
      if (readdata !== 32'h12AB_BEEF) begin
         miscompares++;
         $display("FAIL misalign_suppress: got %h want %h", readdata, 32'h12AB_BEEF);
      end
      do_read(32'hB000_0008);
      vectors++;
      if (readdata !== 32'(exp_stores)) begin
         miscompares++;
         $display("FAIL misalign_stores: got %0d want %0d", readdata, exp_stores);
      end
      do_read(32'h42);
      vectors++;
      if (misalign !== 1'b1) begin
         miscompares++;
         $display("FAIL misalign_read: got %b want %b", misalign, 1'b1);
      end
      do_write(32'h43, 4'b1000, 32'h7700_0000);
      exp_stores++;
      vectors++;
      if (misalign !== 1'b0) begin
         miscompares++;
         $display("FAIL legal_byte: got %b want %b", misalign, 1'b0);
      end
      do_read(32'h40);
      vectors++;
      if (readdata !== 32'h77AB_BEEF) begin
         miscompares++;
         $display("FAIL legal_byte_data: got %h want %h", readdata, 32'h77AB_BEEF);
      end
   endtask
`else
   task automatic test_align();
      do_write(32'h41, 4'b0011, 32'h0000_FFFF);
      exp_stores++;
      do_read(32'h40);
      vectors++;
      if (readdata !== 32'h12AB_FFFF) begin
         miscompares++;
         $display("FAIL unchecked_strobe: got %h want %h", readdata, 32'h12AB_FFFF);
      end
      do_read(32'hB000_0008);
      vectors++;
      if (readdata !== 32'(exp_stores)) begin
         miscompares++;
         $display("FAIL unchecked_stores: got %0d want %0d", readdata, exp_stores);
      end
   endtask
`endif

   task automatic test_reset_midop();
      do_write(32'h80, 4'hF, 32'h1111_1111);
      addr = 32'h80; memwrite = 4'hF; writedata = 32'h2222_2222;
      rst = 1'b0;
      cycle();
      vectors++;
      if (readdata !== 32'h0) begin
         miscompares++;
         $display("FAIL midop_readdata: got %h want %h", readdata, 32'h0);
      end
      vectors++;
      if (led !== 16'h0) begin
         miscompares++;
         $display("FAIL midop_led: got %h want %h", led, 16'h0);
      end
      idle();
      @(negedge clk);
      rst = 1'b1;
      do_read(32'h80);
      vectors++;
      if (readdata !== 32'h1111_1111) begin
         miscompares++;
         $display("FAIL midop_write_lost: got %h want %h", readdata, 32'h1111_1111);
      end
      do_read(32'hB000_0008);
      vectors++;
      if (readdata !== 32'h0) begin
         miscompares++;
         $display("FAIL midop_stores: got %0d want %0d", readdata, 0);
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_store();
      test_same_cycle();
      test_alias();
      test_mmio();
      test_stores();
      test_align();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded %0d time units", 200000);
      $fatal(1);
   end

endmodule
